// File: rtl/lemmings_pkg.sv
// ============================================================================
// Module      : lemmings_pkg
// Description : State encoding and shared constants for the lemming walker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  localparam int unsigned c_FALL_LIMIT_DEFAULT = 20;

  function automatic logic is_fall(input state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

endpackage : lemmings_pkg

`default_nettype wire

// File: rtl/lemmings_fall_timer.sv
// ============================================================================
// Module      : lemmings_fall_timer
// Description : Saturating fall-duration counter; clears whenever run is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lemmings_fall_timer
  import lemmings_pkg::*;
#(
  parameter int unsigned FALL_LIMIT = c_FALL_LIMIT_DEFAULT
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic                               run,
  output logic [$clog2(FALL_LIMIT+1)-1:0]    cnt,
  output logic                               expired
);

  localparam int unsigned CNT_W = $clog2(FALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(FALL_LIMIT);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at the limit instead of wrapping so very long falls still splat.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q >= c_LIMIT) ? cnt_q : (cnt_q + c_ONE);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q >= c_LIMIT);

endmodule : lemmings_fall_timer

`default_nettype wire

// File: rtl/lemmings_walker.sv
// ============================================================================
// Module      : lemmings_walker
// Description : Moore FSM for one lemming: walk, fall, dig (LEMMINGS_DIG_EN), splat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lemmings_walker
  import lemmings_pkg::*;
#(
  parameter int unsigned FALL_LIMIT = c_FALL_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  localparam int unsigned CNT_W = $clog2(FALL_LIMIT + 1);

  state_t           state_q;
  state_t           state_d;
  logic             fall_run;
  logic             fall_expired;
  logic [CNT_W-1:0] fall_cnt_unused;
  logic             dig_req;

`ifdef LEMMINGS_DIG_EN
  assign dig_req = dig;
`else
  logic dig_unused;
  assign dig_unused = dig;
  assign dig_req    = 1'b0;
`endif

  // Counter advances only while the lemming stays airborne, so it reads 0 on
  // the first fall cycle and is cleared as soon as the fall ends.
  assign fall_run = is_fall(state_q) && is_fall(state_d);

  lemmings_fall_timer #(
    .FALL_LIMIT (FALL_LIMIT)
  ) u_fall_timer (
    .clk     (clk),
    .areset  (areset),
    .run     (fall_run),
    .cnt     (fall_cnt_unused),
    .expired (fall_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WALK_L: begin
        if (!ground)        state_d = FALL_L;
        else if (dig_req)   state_d = DIG_L;
        else if (bump_left) state_d = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_d = FALL_R;
        else if (dig_req)    state_d = DIG_R;
        else if (bump_right) state_d = WALK_L;
      end
      FALL_L: begin
        if (ground) state_d = fall_expired ? SPLAT : WALK_L;
      end
      FALL_R: begin
        if (ground) state_d = fall_expired ? SPLAT : WALK_R;
      end
`ifdef LEMMINGS_DIG_EN
      DIG_L: begin
        if (!ground) state_d = FALL_L;
      end
      DIG_R: begin
        if (!ground) state_d = FALL_R;
      end
`endif
      SPLAT: begin
        state_d = SPLAT;
      end
      default: begin
        state_d = WALK_L;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= WALK_L;
    end else begin
      state_q <= state_d;
    end
  end

  assign walk_left  = (state_q == WALK_L);
  assign walk_right = (state_q == WALK_R);
  assign aaah       = is_fall(state_q);
  assign splat      = (state_q == SPLAT);
`ifdef LEMMINGS_DIG_EN
  assign digging    = (state_q == DIG_L) || (state_q == DIG_R);
`else
  assign digging    = 1'b0;
`endif

endmodule : lemmings_walker

`default_nettype wire

// File: tb/tb_lemmings_walker.sv
// ============================================================================
// Module      : tb_lemmings_walker
// Description : Scoreboard bench for lemmings_walker against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lemmings_walker;

  localparam int LIMIT = 20;
`ifdef LEMMINGS_DIG_EN
  localparam bit DIG_EN = 1'b1;
`else
  localparam bit DIG_EN = 1'b0;
`endif

  localparam int M_WALK  = 0;
  localparam int M_FALL  = 1;
  localparam int M_DIG   = 2;
  localparam int M_SPLAT = 3;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic bump_left = 1'b0;
  logic bump_right = 1'b0;
  logic ground = 1'b1;
  logic dig = 1'b0;
  logic walk_left, walk_right, aaah, digging, splat;

  lemmings_walker #(
    .FALL_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .ground     (ground),
    .dig        (dig),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .splat      (splat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: activity, facing direction, cycles spent airborne.
  int m_mode = M_WALK;
  bit m_right = 1'b0;
  int m_nfall = 0;

  function automatic logic [4:0] model_out();
    logic [4:0] v;
    v = 5'b0;
    v[4] = (m_mode == M_WALK) && !m_right;
    v[3] = (m_mode == M_WALK) &&  m_right;
    v[2] = (m_mode == M_FALL);
    v[1] = (m_mode == M_DIG);
    v[0] = (m_mode == M_SPLAT);
    return v;
  endfunction

  task automatic model_reset();
    m_mode  = M_WALK;
    m_right = 1'b0;
    m_nfall = 0;
  endtask

  task automatic model_step(input bit bl, input bit br, input bit g, input bit d);
    case (m_mode)
      M_WALK: begin
        if (!g) begin
          m_mode = M_FALL; m_nfall = 1;
        end else if (DIG_EN && d) begin
          m_mode = M_DIG;
        end else if (!m_right && bl) begin
          m_right = 1'b1;
        end else if (m_right && br) begin
          m_right = 1'b0;
        end
      end
      M_FALL: begin
        if (g) m_mode = (m_nfall > LIMIT) ? M_SPLAT : M_WALK;
        else   m_nfall++;
      end
      M_DIG: begin
        if (!g) begin
          m_mode = M_FALL; m_nfall = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.exp = model_out();
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic drive(input bit bl, input bit br, input bit g, input bit d, input string tag);
    @(negedge clk);
    areset = 1'b0; bump_left = bl; bump_right = br; ground = g; dig = d;
    model_step(bl, br, g, d);
    push(tag);
  endtask

  task automatic reset_cycle(input string tag);
    @(negedge clk);
    areset = 1'b1; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;
    model_reset();
    push(tag);
  endtask

  // Reset raised between clock edges must take effect without waiting for clk.
  task automatic async_reset_mid(input string tag);
    logic [4:0] act;
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    act = {walk_left, walk_right, aaah, digging, splat};
    checks++;
    if (act !== 5'b10000) begin
      failures++;
      $display("FAIL %s_async: got %b expected %b", tag, act, 5'b10000);
    end
    model_reset();
    push(tag);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = {walk_left, walk_right, aaah, digging, splat};
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s @%0t: got %b expected %b (wl,wr,aaah,dig,splat)", e.tag, $time, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int gap;
    int splat_cycles;
    bit g;

    reset_cycle("t1_reset");
    drive(0, 0, 1, 0, "t1_release");
    drive(1, 0, 1, 0, "t1_bump_left");

    drive(1, 0, 1, 0, "t2_opposite_bump");
    drive(0, 1, 1, 0, "t2_bump_right");
    drive(1, 1, 1, 0, "t2_both_bumps");

    for (int i = 0; i < LIMIT; i++) drive(0, 0, 0, 0, "t3_fall");
    drive(0, 0, 1, 0, "t3_land_safe");
    drive(0, 0, 1, 0, "t3_walk_after");

    for (int i = 0; i < LIMIT + 1; i++) drive(1, 1, 0, 1, "t4_fall");
    drive(0, 0, 1, 0, "t4_land_splat");
    for (int i = 0; i < 50; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "t4_splat_hold");
    reset_cycle("t4_reset");
    drive(0, 0, 1, 0, "t4_after_reset");

    drive(1, 0, 1, 1, "t5_dig_and_bump");
    drive(1, 1, 1, 1, "t5_dig_hold");
    drive(0, 0, 0, 0, "t5_dig_fall");
    drive(0, 0, 1, 0, "t5_dig_land");
    drive(0, 0, 1, 1, "t5_dig_only");
    reset_cycle("t5_reset");

    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, "t6_fall_pre");
    async_reset_mid("t6_async_reset");
    drive(0, 0, 1, 0, "t6_release");
    for (int i = 0; i < LIMIT; i++) drive(0, 0, 0, 0, "t6_fall_again");
    drive(0, 0, 1, 0, "t6_land_safe");

    gap = 0;
    splat_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == M_SPLAT) splat_cycles++;
      else splat_cycles = 0;
      if (splat_cycles > 8 || $urandom_range(0, 299) == 0) begin
        reset_cycle("rnd_reset");
        gap = 0;
      end else begin
        if (gap > 0) begin
          g = 1'b0; gap--;
        end else if ($urandom_range(0, 14) == 0) begin
          g = 1'b0; gap = $urandom_range(0, LIMIT + 3);
        end else begin
          g = 1'b1;
        end
        drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), g,
              1'($urandom_range(0, 19) == 0), "rnd");
      end
    end

    drive(0, 0, 1, 0, "drain");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lemmings_walker

`default_nettype wire
